bp_update_sched: RTL and testbench

- Front-end scheduler for the hybrid branch predictor's update port and table initialisation.
- After reset, sweeps every predictor table index once, issuing one init write per cycle.
- It then accepts resolved-branch updates from two execute lanes, queues them in a small FIFO, and issues at most one update per cycle to the predictor.
- Sits between the execute/commit stages and the predictor. It is the only source of the predictor's update and init signals.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_upd_fifo.sv | 84 ++++++++
 rtl/bp_update_sched.sv | 207 ++++++++++++++++++++
 tb/tb_bp_update_sched.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and defaults for the branch predictor update scheduler
//
// Purpose: the update record carried from the execute lanes to the predictor,
// the scheduler state encoding and the default widths.
// Ports: none (package).

package bp_pkg;

  localparam int BP_PC_W     = 32;
  localparam int BP_IDX_BITS = 12;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_sched_state_e;

  // Reference layout of one queued update at the default PC width.
  typedef struct packed {
    logic [BP_PC_W-1:0] pc;
    logic               taken;
    logic               mispredict;
  } bp_upd_t;

endpackage

// File: rtl/bp_upd_fifo.sv
// rtl/bp_upd_fifo.sv - two-write / one-read update queue with occupancy output
//
// Purpose: holds resolved-branch updates between acceptance and issue. When both
// write ports fire in the same cycle, data0 lands in the older slot.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   clr_i              synchronous discard of all entries
//   push0_i, data0_i   first (older) write port
//   push1_i, data1_i   second (younger) write port
//   pop_i              remove head entry
//   head_o             current head entry
//   level_o            occupancy, 0..DEPTH
//   empty_o            occupancy is zero
// The caller guarantees no push beyond DEPTH and no pop when empty.

module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter type entry_t = bp_upd_t,
  parameter int  DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             push0_i,
  input  entry_t           data0_i,
  input  logic             push1_i,
  input  entry_t           data1_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [LVL_W-1:0] level_o,
  output logic             empty_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [LVL_W-1:0] level_q, level_d;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own.
  always_comb begin
    wr_ptr_nxt = wr_ptr_q + PTR_W'(1);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_i);
    level_d    = level_q + LVL_W'(push0_i) + LVL_W'(push1_i) - LVL_W'(pop_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (!clr_i) begin
      if (push0_i) begin
        mem_q[wr_ptr_q] <= data0_i;
      end
      if (push1_i) begin
        mem_q[push0_i ? wr_ptr_nxt : wr_ptr_q] <= data1_i;
      end
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/bp_update_sched.sv
// rtl/bp_update_sched.sv - predictor table init sweep and two-lane update scheduler
//
// Purpose: after reset, writes every predictor table index once (one per cycle),
// then accepts resolved branches from two execute lanes into a small queue and
// issues at most one registered update per cycle to the predictor.
// Optional build macro: BP_UPD_STATS_EN adds update / mispredict counters.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   flush                           discard all queued updates (ignored during init)
//   req{0,1}_valid/_ready           lane handshake
//   req{0,1}_pc/_taken/_mispredict  lane payload
//   bp_update, bp_update_pc,
//   bp_taken, bp_mispredict         registered update to the predictor
//   bp_init_we, bp_init_idx         table init write strobe and index
//   bp_busy                         init sweep in progress, lookups must stall
//   fifo_level                      current queue occupancy
//   stat_updates, stat_mispredicts  (BP_UPD_STATS_EN only) issued update counts

module bp_update_sched
  import bp_pkg::*;
#(
  parameter int  PC_W       = BP_PC_W,
  parameter int  IDX_BITS   = BP_IDX_BITS,
  parameter int  FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [PC_W-1:0]     req0_pc,
  input  logic                req0_taken,
  input  logic                req0_mispredict,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [PC_W-1:0]     req1_pc,
  input  logic                req1_taken,
  input  logic                req1_mispredict,
  output logic                bp_update,
  output logic [PC_W-1:0]     bp_update_pc,
  output logic                bp_taken,
  output logic                bp_mispredict,
  output logic                bp_init_we,
  output logic [IDX_BITS-1:0] bp_init_idx,
  output logic                bp_busy,
  output logic [LVL_W-1:0]    fifo_level
`ifdef BP_UPD_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);

  // Same layout as bp_upd_t, sized to this instance's PC width.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            taken;
    logic            mispredict;
  } upd_t;

  bp_sched_state_e     state_q, state_d;
  logic [IDX_BITS-1:0] init_idx_q, init_idx_d;
  logic                rr_q, rr_d;

  logic                ready0, ready1;
  logic                push0, push1;
  logic                pop, clr;
  logic [LVL_W-1:0]    level;
  logic [LVL_W-1:0]    free;
  logic                fifo_empty;
  upd_t                wdata0, wdata1, head;

  logic                upd_q;
  logic [PC_W-1:0]     upd_pc_q;
  logic                upd_taken_q;
  logic                upd_mp_q;

  assign free   = LVL_W'(FIFO_DEPTH) - level;
  assign push0  = req0_valid & ready0;
  assign push1  = req1_valid & ready1;
  assign wdata0 = '{pc: req0_pc, taken: req0_taken, mispredict: req0_mispredict};
  assign wdata1 = '{pc: req1_pc, taken: req1_taken, mispredict: req1_mispredict};

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    rr_d       = rr_q;
    ready0     = 1'b0;
    ready1     = 1'b0;
    pop        = 1'b0;
    clr        = 1'b0;
    bp_init_we = 1'b0;
    bp_busy    = 1'b0;
    case (state_q)
      INIT: begin
        bp_init_we = 1'b1;
        bp_busy    = 1'b1;
        init_idx_d = init_idx_q + IDX_BITS'(1);
        if (init_idx_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          clr = 1'b1;
        end else begin
          // Readiness uses registered occupancy only; a same-cycle pop never
          // opens an extra slot.
          if (free >= LVL_W'(2)) begin
            ready0 = 1'b1;
            ready1 = 1'b1;
          end else if (free == LVL_W'(1)) begin
            if (req0_valid && req1_valid) begin
              ready0 = ~rr_q;
              ready1 = rr_q;
              rr_d   = ~rr_q;
            end else begin
              ready0 = req0_valid;
              ready1 = req1_valid;
            end
          end
          pop = ~fifo_empty;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      rr_q       <= rr_d;
    end
  end

  // Payload holds its last value when nothing is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_q       <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      upd_mp_q    <= 1'b0;
    end else begin
      upd_q <= pop;
      if (pop) begin
        upd_pc_q    <= head.pc;
        upd_taken_q <= head.taken;
        upd_mp_q    <= head.mispredict;
      end
    end
  end

  bp_upd_fifo #(
    .entry_t (upd_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (clr),
    .push0_i (push0),
    .data0_i (wdata0),
    .push1_i (push1),
    .data1_i (wdata1),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level),
    .empty_o (fifo_empty)
  );

`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_upd_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_upd_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      if (upd_q) begin
        stat_upd_q <= stat_upd_q + 32'd1;
      end
      if (upd_q && upd_mp_q) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_updates     = stat_upd_q;
  assign stat_mispredicts = stat_mp_q;
`endif

  assign req0_ready    = ready0;
  assign req1_ready    = ready1;
  assign bp_update     = upd_q;
  assign bp_update_pc  = upd_pc_q;
  assign bp_taken      = upd_taken_q;
  assign bp_mispredict = upd_mp_q;
  assign bp_init_idx   = init_idx_q;
  assign fifo_level    = level;

endmodule

// File: tb/tb_bp_update_sched.sv
// tb/tb_bp_update_sched.sv - self-checking bench for bp_update_sched (IDX_BITS=4, depth 4)

module tb_bp_update_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        req0_valid, req0_ready, req0_taken, req0_mispredict;
  logic [31:0] req0_pc;
  logic        req1_valid, req1_ready, req1_taken, req1_mispredict;
  logic [31:0] req1_pc;
  logic        bp_update, bp_taken, bp_mispredict, bp_init_we, bp_busy;
  logic [31:0] bp_update_pc;
  logic [3:0]  bp_init_idx;
  logic [2:0]  fifo_level;
`ifdef BP_UPD_STATS_EN
  logic [31:0] stat_updates, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  bp_update_sched #(
    .PC_W       (32),
    .IDX_BITS   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .req0_valid      (req0_valid),
    .req0_ready      (req0_ready),
    .req0_pc         (req0_pc),
    .req0_taken      (req0_taken),
    .req0_mispredict (req0_mispredict),
    .req1_valid      (req1_valid),
    .req1_ready      (req1_ready),
    .req1_pc         (req1_pc),
    .req1_taken      (req1_taken),
    .req1_mispredict (req1_mispredict),
    .bp_update       (bp_update),
    .bp_update_pc    (bp_update_pc),
    .bp_taken        (bp_taken),
    .bp_mispredict   (bp_mispredict),
    .bp_init_we      (bp_init_we),
    .bp_init_idx     (bp_init_idx),
    .bp_busy         (bp_busy),
    .fifo_level      (fifo_level)
`ifdef BP_UPD_STATS_EN
    ,
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic        mp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic       r0, r1, upd;
  logic [2:0] lvl;

  // Scoreboard: every issued update must be the oldest accepted, not-yet-discarded entry.
  always @(negedge clk) begin
    if (!reset && bp_update === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_update: got pc=%h, required no update", bp_update_pc);
      end else begin
        mon_e = sb.pop_front();
        if (bp_update_pc !== mon_e.pc || bp_taken !== mon_e.taken || bp_mispredict !== mon_e.mp) begin
          n_fail++;
          $display("FAIL sb_update: got pc=%h t=%b m=%b, required pc=%h t=%b m=%b",
                   bp_update_pc, bp_taken, bp_mispredict, mon_e.pc, mon_e.taken, mon_e.mp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  // One cycle: drive at edge+1, sample at edge+2, record accepts, return at next edge+1.
  task automatic lane_cycle(input logic v0, input logic [31:0] p0, input logic t0, input logic m0,
                            input logic v1, input logic [31:0] p1, input logic t1, input logic m1,
                            input logic fl);
    exp_t e;
    req0_valid = v0; req0_pc = p0; req0_taken = t0; req0_mispredict = m0;
    req1_valid = v1; req1_pc = p1; req1_taken = t1; req1_mispredict = m1;
    flush = fl;
    #1;
    r0 = req0_ready; r1 = req1_ready; lvl = fifo_level; upd = bp_update;
    if (v0 && r0) begin e.pc = p0; e.taken = t0; e.mp = m0; sb.push_back(e); end
    if (v1 && r1) begin e.pc = p1; e.taken = t1; e.mp = m1; sb.push_back(e); end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    lane_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pc_of(input int lane, input int n);
    return (lane == 0 ? 32'h1000 : 32'h2000) + 32'(n * 4);
  endfunction

  // Called with reset asserted, at edge+1; releases reset and checks the whole sweep.
  task automatic test_init_sweep();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      flush = (i % 3 == 1);
      #1;
      n_cmp += 6;
      if (bp_init_idx !== 4'(i)) begin n_fail++; $display("FAIL init_idx[%0d]: got %0d, required %0d", i, bp_init_idx, i); end
      if (bp_init_we !== 1'b1) begin n_fail++; $display("FAIL init_we[%0d]: got %b, required 1", i, bp_init_we); end
      if (bp_busy !== 1'b1) begin n_fail++; $display("FAIL init_busy[%0d]: got %b, required 1", i, bp_busy); end
      if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready0[%0d]: got %b, required 0", i, req0_ready); end
      if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL init_ready1[%0d]: got %b, required 0", i, req1_ready); end
      if (bp_update !== 1'b0) begin n_fail++; $display("FAIL init_update[%0d]: got %b, required 0", i, bp_update); end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
    #1;
    n_cmp += 3;
    if (bp_busy !== 1'b0) begin n_fail++; $display("FAIL sweep_end_busy: got %b, required 0", bp_busy); end
    if (bp_init_we !== 1'b0) begin n_fail++; $display("FAIL sweep_end_we: got %b, required 0", bp_init_we); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL sweep_end_level: got %0d, required 0", fifo_level); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_cmp += 10;
    if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready0: got %b, required 0", req0_ready); end
    if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready1: got %b, required 0", req1_ready); end
    if (bp_init_we !== 1'b1) begin n_fail++; $display("FAIL rst_init_we: got %b, required 1", bp_init_we); end
    if (bp_init_idx !== 4'd0) begin n_fail++; $display("FAIL rst_init_idx: got %0d, required 0", bp_init_idx); end
    if (bp_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b, required 1", bp_busy); end
    if (bp_update !== 1'b0) begin n_fail++; $display("FAIL rst_update: got %b, required 0", bp_update); end
    if (bp_update_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, required 0", bp_update_pc); end
    if (bp_taken !== 1'b0) begin n_fail++; $display("FAIL rst_taken: got %b, required 0", bp_taken); end
    if (bp_mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mp: got %b, required 0", bp_mispredict); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d, required 0", fifo_level); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    test_init_sweep();
  endtask

  task automatic test_single();
    lane_cycle(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp += 2;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL single_ready0: got %b, required 1", r0); end
    if (lvl !== 3'd0) begin n_fail++; $display("FAIL single_lvl0: got %0d, required 0", lvl); end
    idle_cycle();
    n_cmp += 2;
    if (lvl !== 3'd1) begin n_fail++; $display("FAIL single_lvl1: got %0d, required 1", lvl); end
    if (upd !== 1'b0) begin n_fail++; $display("FAIL single_early: got %b, required 0", upd); end
    idle_cycle();
    n_cmp += 2;
    if (upd !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b, required 1", upd); end
    if (lvl !== 3'd0) begin n_fail++; $display("FAIL single_lvl2: got %0d, required 0", lvl); end
    idle_cycle();
    n_cmp += 2;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL single_one_cycle: got %b, required 0", upd); end
    if (bp_update_pc !== 32'h100) begin n_fail++; $display("FAIL single_hold_pc: got %h, required 100", bp_update_pc); end
  endtask

  task automatic test_dual();
    lane_cycle(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 32'h204, 1'b1, 1'b0, 1'b0);
    n_cmp += 2;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL dual_ready0: got %b, required 1", r0); end
    if (r1 !== 1'b1) begin n_fail++; $display("FAIL dual_ready1: got %b, required 1", r1); end
    idle_cycle();
    n_cmp += 2;
    if (lvl !== 3'd2) begin n_fail++; $display("FAIL dual_lvl: got %0d, required 2", lvl); end
    if (upd !== 1'b0) begin n_fail++; $display("FAIL dual_early: got %b, required 0", upd); end
    idle_cycle();
    n_cmp += 2;
    if (upd !== 1'b1) begin n_fail++; $display("FAIL dual_issue0: got %b, required 1", upd); end
    if (lvl !== 3'd1) begin n_fail++; $display("FAIL dual_lvl1: got %0d, required 1", lvl); end
    idle_cycle();
    n_cmp += 1;
    if (upd !== 1'b1) begin n_fail++; $display("FAIL dual_issue1: got %b, required 1", upd); end
    idle_cycle();
    n_cmp += 2;
    if (upd !== 1'b0) begin n_fail++; $display("FAIL dual_done: got %b, required 0", upd); end
    if (sb.size() != 0) begin n_fail++; $display("FAIL dual_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_contention();
    int  n0 = 0;
    int  n1 = 0;
    logic er0, er1;
    logic [2:0] elvl;
    for (int k = 0; k < 10; k++) begin
      lane_cycle(1'b1, pc_of(0, n0), n0[0], n0[1], 1'b1, pc_of(1, n1), ~n1[0], n1[2], 1'b0);
      elvl = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : 3'd3;
      er0  = (k < 2) || ((k - 2) % 2 == 0);
      er1  = (k < 2) || ((k - 2) % 2 == 1);
      n_cmp += 3;
      if (lvl !== elvl) begin n_fail++; $display("FAIL cont_lvl[%0d]: got %0d, required %0d", k, lvl, elvl); end
      if (r0 !== er0) begin n_fail++; $display("FAIL cont_ready0[%0d]: got %b, required %b", k, r0, er0); end
      if (r1 !== er1) begin n_fail++; $display("FAIL cont_ready1[%0d]: got %b, required %b", k, r1, er1); end
      if (r0 === 1'b1) n0++;
      if (r1 === 1'b1) n1++;
    end
    repeat (6) idle_cycle();
    n_cmp += 4;
    if (n0 != 6) begin n_fail++; $display("FAIL cont_grants0: got %0d, required 6", n0); end
    if (n1 != 6) begin n_fail++; $display("FAIL cont_grants1: got %0d, required 6", n1); end
    if (sb.size() != 0) begin n_fail++; $display("FAIL cont_drain: got %0d pending, required 0", sb.size()); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL cont_level: got %0d, required 0", fifo_level); end
  endtask

  task automatic test_flush();
    lane_cycle(1'b1, 32'h3000, 1'b0, 1'b0, 1'b1, 32'h3004, 1'b1, 1'b1, 1'b0);
    lane_cycle(1'b1, 32'h3008, 1'b1, 1'b0, 1'b1, 32'h300c, 1'b0, 1'b1, 1'b0);
    n_cmp += 1;
    if (lvl !== 3'd2) begin n_fail++; $display("FAIL flush_pre_lvl: got %0d, required 2", lvl); end
    lane_cycle(1'b1, 32'h3010, 1'b1, 1'b1, 1'b1, 32'h3014, 1'b1, 1'b1, 1'b1);
    n_cmp += 4;
    if (r0 !== 1'b0) begin n_fail++; $display("FAIL flush_ready0: got %b, required 0", r0); end
    if (r1 !== 1'b0) begin n_fail++; $display("FAIL flush_ready1: got %b, required 0", r1); end
    if (lvl !== 3'd3) begin n_fail++; $display("FAIL flush_lvl3: got %0d, required 3", lvl); end
    if (upd !== 1'b1) begin n_fail++; $display("FAIL flush_prior_issue: got %b, required 1", upd); end
    sb.delete();
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      n_cmp += 2;
      if (lvl !== 3'd0) begin n_fail++; $display("FAIL flush_lvl_after[%0d]: got %0d, required 0", i, lvl); end
      if (upd !== 1'b0) begin n_fail++; $display("FAIL flush_no_update[%0d]: got %b, required 0", i, upd); end
    end
  endtask

`ifdef BP_UPD_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    sb.delete();
    #1;
    @(posedge clk); #1;
    test_init_sweep();
    for (int i = 0; i < 5; i++) begin
      lane_cycle(1'b1, 32'h600 + 32'(i * 4), i[0], (i == 0 || i == 2), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    repeat (4) idle_cycle();
    n_cmp += 2;
    if (stat_updates !== 32'd5) begin n_fail++; $display("FAIL stat_upd: got %0d, required 5", stat_updates); end
    if (stat_mispredicts !== 32'd2) begin n_fail++; $display("FAIL stat_mp: got %0d, required 2", stat_mispredicts); end
    lane_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    n_cmp += 2;
    if (stat_updates !== 32'd5) begin n_fail++; $display("FAIL stat_upd_flush: got %0d, required 5", stat_updates); end
    if (stat_mispredicts !== 32'd2) begin n_fail++; $display("FAIL stat_mp_flush: got %0d, required 2", stat_mispredicts); end
    flush = 1'b0;
    reset = 1'b1;
    #1;
    n_cmp += 2;
    if (stat_updates !== 32'd0) begin n_fail++; $display("FAIL stat_upd_rst: got %0d, required 0", stat_updates); end
    if (stat_mispredicts !== 32'd0) begin n_fail++; $display("FAIL stat_mp_rst: got %0d, required 0", stat_mispredicts); end
    @(posedge clk); #1;
    test_init_sweep();
  endtask
`endif

  task automatic test_reset_mid_run();
    lane_cycle(1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    n_cmp += 1;
    if (r0 !== 1'b1) begin n_fail++; $display("FAIL mid_ready0: got %b, required 1", r0); end
    lane_cycle(1'b1, 32'h404, 1'b0, 1'b0, 1'b1, 32'h408, 1'b1, 1'b0, 1'b0);
    n_cmp += 2;
    if (lvl !== 3'd1) begin n_fail++; $display("FAIL mid_lvl1: got %0d, required 1", lvl); end
    if (r0 !== 1'b1 || r1 !== 1'b1) begin n_fail++; $display("FAIL mid_dual_ready: got %b%b, required 11", r0, r1); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp += 2;
    if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL mid_pre_lvl: got %0d, required 2", fifo_level); end
    if (bp_update !== 1'b1) begin n_fail++; $display("FAIL mid_pre_update: got %b, required 1", bp_update); end
    reset = 1'b1;
    #1;
    n_cmp += 5;
    if (bp_update !== 1'b0) begin n_fail++; $display("FAIL mid_rst_update: got %b, required 0", bp_update); end
    if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL mid_rst_lvl: got %0d, required 0", fifo_level); end
    if (bp_busy !== 1'b1) begin n_fail++; $display("FAIL mid_rst_busy: got %b, required 1", bp_busy); end
    if (bp_init_we !== 1'b1) begin n_fail++; $display("FAIL mid_rst_we: got %b, required 1", bp_init_we); end
    if (bp_init_idx !== 4'd0) begin n_fail++; $display("FAIL mid_rst_idx: got %0d, required 0", bp_init_idx); end
    sb.delete();
    @(posedge clk); #1;
    test_init_sweep();
    lane_cycle(1'b1, 32'h500, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (4) idle_cycle();
    n_cmp += 1;
    if (sb.size() != 0) begin n_fail++; $display("FAIL mid_post_drain: got %0d pending, required 0", sb.size()); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_pc = '0; req0_taken = 1'b0; req0_mispredict = 1'b0;
    req1_valid = 1'b0; req1_pc = '0; req1_taken = 1'b0; req1_mispredict = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_dual();
    test_contention();
    test_flush();
`ifdef BP_UPD_STATS_EN
    test_stats();
`endif
    test_reset_mid_run();
    n_cmp += 1;
    if (sb.size() != 0) begin n_fail++; $display("FAIL final_drain: got %0d pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
